// File: rtl/vdp_pkg.sv
// rtl/vdp_pkg.sv - shared constants, types and width helper for the vector dot product
// Contents:
//    DEF_DATA_WIDTH, DEF_VECTOR_SIZE : default element width and vector length
//    LATENCY                         : in_valid -> out_valid pipeline depth
//    tree_width()                    : full-precision width of the summed products
//    vdp_sum_t                       : full-precision sum type for the default sizes
package vdp_pkg;

   localparam int DEF_DATA_WIDTH  = 31;
   localparam int DEF_VECTOR_SIZE = 4;
   localparam int LATENCY         = 2;

   // A product needs 2*dw bits; summing n of them grows by clog2(n) bits.
   function automatic int tree_width(input int dw, input int n);
      return 2 * dw + $clog2(n);
   endfunction

   typedef logic [tree_width(DEF_DATA_WIDTH, DEF_VECTOR_SIZE)-1:0] vdp_sum_t;

endpackage

// File: rtl/vdp_adder_tree.sv
// rtl/vdp_adder_tree.sv - combinational pairwise reduction of N operands to one sum
// Ports:
//    i_data [N] : W-bit operands, already extended to the full sum width
//    o_sum      : W-bit sum of all operands (W must be wide enough to not wrap)
module vdp_adder_tree #(
   parameter int N = 4,
   parameter int W = 64
) (
   input  logic [W-1:0] i_data [N],
   output logic [W-1:0] o_sum
);

   localparam int LEVELS = (N > 1) ? $clog2(N) : 0;

   // w_node[lev][k]: k-th live value at level lev; slots past the live count tie to 0.
   logic [W-1:0] w_node [LEVELS+1][N];

   for (genvar k = 0; k < N; k++) begin : g_in
      assign w_node[0][k] = i_data[k];
   end

   for (genvar lev = 0; lev < LEVELS; lev++) begin : g_lev
      // Live values at this level: ceil(N / 2^lev).
      localparam int CNT = (N + (1 << lev) - 1) >> lev;
      for (genvar k = 0; k < N; k++) begin : g_node
         if (k < CNT / 2) begin : g_add
            assign w_node[lev+1][k] = w_node[lev][2*k] + w_node[lev][2*k+1];
         end else if ((k == CNT / 2) && (CNT % 2 == 1)) begin : g_pass
            // Odd element out carries forward unchanged.
            assign w_node[lev+1][k] = w_node[lev][2*k];
         end else begin : g_idle
            assign w_node[lev+1][k] = '0;
         end
      end
   end

   assign o_sum = w_node[LEVELS][0];

endmodule

// File: rtl/vector_dot_product.sv
// rtl/vector_dot_product.sv - two-stage pipelined unsigned dot product of two vectors
// Ports:
//    clk, rst_n         : clock (rising edge), asynchronous active-low reset
//    in_valid           : vec1/vec2 carry an operand pair this cycle
//    vec1, vec2         : VECTOR_SIZE elements of DATA_WIDTH bits each
//    out_valid          : result/overflow valid, LATENCY cycles after in_valid
//    result             : dot product modulo 2^DATA_WIDTH
//    overflow           : full-precision sum exceeded DATA_WIDTH bits
module vector_dot_product
   import vdp_pkg::*;
#(
   parameter int VECTOR_SIZE = DEF_VECTOR_SIZE,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] vec1 [0:VECTOR_SIZE-1],
   input  logic [DATA_WIDTH-1:0] vec2 [0:VECTOR_SIZE-1],
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  overflow
);

   localparam int PROD_W = 2 * DATA_WIDTH;
   localparam int SUM_W  = tree_width(DATA_WIDTH, VECTOR_SIZE);

   logic [PROD_W-1:0]  r_prod [VECTOR_SIZE];
   logic [SUM_W-1:0]   w_prod_ext [VECTOR_SIZE];
   logic [SUM_W-1:0]   w_tree_sum;
   logic [SUM_W-1:0]   r_sum;
   logic [LATENCY-1:0] r_valid;

   // Stage 1: products load only on a valid pair so idle cycles keep the data stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < VECTOR_SIZE; i++) begin
            r_prod[i] <= '0;
         end
      end else if (in_valid) begin
         for (int i = 0; i < VECTOR_SIZE; i++) begin
            r_prod[i] <= PROD_W'(vec1[i]) * PROD_W'(vec2[i]);
         end
      end
   end

   for (genvar g = 0; g < VECTOR_SIZE; g++) begin : g_ext
      assign w_prod_ext[g] = SUM_W'(r_prod[g]);
   end

   vdp_adder_tree #(
      .N (VECTOR_SIZE),
      .W (SUM_W)
   ) u_tree (
      .i_data (w_prod_ext),
      .o_sum  (w_tree_sum)
   );

   // Stage 2: sum captured only when stage 1 holds a live pair, so outputs hold between results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum <= '0;
      end else if (r_valid[0]) begin
         r_sum <= w_tree_sum;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else begin
         r_valid <= {r_valid[LATENCY-2:0], in_valid};
      end
   end

   assign out_valid = r_valid[LATENCY-1];
   assign result    = r_sum[DATA_WIDTH-1:0];
   assign overflow  = |r_sum[SUM_W-1:DATA_WIDTH];

endmodule

// File: tb/tb_vector_dot_product.sv
// tb/tb_vector_dot_product.sv - directed self-checking bench for vector_dot_product
module tb_vector_dot_product;

   localparam int DW = 31;
   localparam int VS = 4;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic [DW-1:0] vec1 [0:VS-1];
   logic [DW-1:0] vec2 [0:VS-1];
   logic          out_valid;
   logic [DW-1:0] result;
   logic          overflow;

   int n_cmp;
   int n_bad;

   vector_dot_product #(
      .VECTOR_SIZE (VS),
      .DATA_WIDTH  (DW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .vec1      (vec1),
      .vec2      (vec2),
      .out_valid (out_valid),
      .result    (result),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; sample point is 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vecs(input logic [DW-1:0] a0, a1, a2, a3,
                           input logic [DW-1:0] b0, b1, b2, b3);
      vec1[0] = a0; vec1[1] = a1; vec1[2] = a2; vec1[3] = a3;
      vec2[0] = b0; vec2[1] = b1; vec2[2] = b2; vec2[3] = b3;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < VS; i++) begin
         vec1[i] = DW'($urandom);
         vec2[i] = DW'($urandom);
      end
      tick();
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
      n_cmp++;
      if (result !== '0) begin n_bad++; $display("FAIL reset_result got %0d want 0", result); end
      n_cmp++;
      if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", overflow); end
      in_valid = 1'b0;
      rst_n    = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         n_cmp++;
         if (out_valid !== 1'b0 || result !== '0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle cyc%0d got v=%b r=%0d o=%b want 0/0/0", c, out_valid, result, overflow);
         end
      end
   endtask

   // Single pulse; checks latency is exactly 2 and that outputs hold afterwards.
   task automatic run_single(input string name, input logic [DW-1:0] exp_r, input logic exp_o);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      // Scramble inputs while idle: the pipeline must not pick them up.
      set_vecs(7, 7, 7, 7, 9, 9, 9, 9);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_early got out_valid=%b want 0", name, out_valid); end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL %s_valid got %b want 1", name, out_valid); end
      n_cmp++;
      if (result !== exp_r) begin n_bad++; $display("FAIL %s_result got %0d want %0d", name, result, exp_r); end
      n_cmp++;
      if (overflow !== exp_o) begin n_bad++; $display("FAIL %s_ovf got %b want %b", name, overflow, exp_o); end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || result !== exp_r || overflow !== exp_o) begin
         n_bad++;
         $display("FAIL %s_hold got v=%b r=%0d o=%b want 0/%0d/%b", name, out_valid, result, overflow, exp_r, exp_o);
      end
   endtask

   task automatic test_basic();
      set_vecs(0, 1, 2, 3, 4, 5, 6, 7);
      run_single("basic", DW'(38), 1'b0);
   endtask

   task automatic test_zero();
      set_vecs(0, 0, 0, 0, 0, 0, 0, 0);
      run_single("zero", DW'(0), 1'b0);
   endtask

   task automatic test_boundary();
      // Exactly 2^31-1: largest sum that still fits.
      set_vecs(31'h7FFF_FFFF, 0, 0, 0, 1, 0, 0, 0);
      run_single("max_fit", 31'h7FFF_FFFF, 1'b0);
      // 2^30 * 2 = 2^31: first value that spills.
      set_vecs(31'h4000_0000, 0, 0, 0, 2, 0, 0, 0);
      run_single("just_over", DW'(0), 1'b1);
      // Four products of (2^31-1)^2 = 2^64 - 2^34 + 4; low 31 bits = 4.
      set_vecs(31'h7FFF_FFFF, 31'h7FFF_FFFF, 31'h7FFF_FFFF, 31'h7FFF_FFFF,
               31'h7FFF_FFFF, 31'h7FFF_FFFF, 31'h7FFF_FFFF, 31'h7FFF_FFFF);
      run_single("all_max", DW'(4), 1'b1);
   endtask

   task automatic test_overflow();
      // 2^30 * 2^30 = 2^60
      set_vecs(31'h4000_0000, 0, 0, 0, 31'h4000_0000, 0, 0, 0);
      run_single("ovf_2p60", DW'(0), 1'b1);
      // 4 * 2^32 = 2^34
      set_vecs(31'h1_0000, 31'h1_0000, 31'h1_0000, 31'h1_0000,
               31'h1_0000, 31'h1_0000, 31'h1_0000, 31'h1_0000);
      run_single("ovf_2p34", DW'(0), 1'b1);
      // Wrap with non-zero remainder: 2^31 + 5 -> result 5.
      set_vecs(31'h4000_0000, 5, 0, 0, 2, 1, 0, 0);
      run_single("ovf_wrap5", DW'(5), 1'b1);
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] exp_r [3];
      exp_r[0] = DW'(4);
      exp_r[1] = DW'(10);
      exp_r[2] = DW'(38);
      for (int c = 0; c < 5; c++) begin
         in_valid = (c < 3);
         if (c == 0) set_vecs(1, 1, 1, 1, 1, 1, 1, 1);
         else if (c == 1) set_vecs(2, 0, 0, 0, 5, 0, 0, 0);
         else if (c == 2) set_vecs(0, 1, 2, 3, 4, 5, 6, 7);
         else set_vecs(3, 3, 3, 3, 3, 3, 3, 3);
         tick();
         if (c >= 1 && c <= 3) begin
            n_cmp++;
            if (out_valid !== 1'b1 || result !== exp_r[c-1] || overflow !== 1'b0) begin
               n_bad++;
               $display("FAIL stream_%0d got v=%b r=%0d o=%b want 1/%0d/0", c - 1, out_valid, result, overflow, exp_r[c-1]);
            end
         end else begin
            n_cmp++;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_gap cyc%0d got out_valid=%b want 0", c, out_valid); end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_midflight();
      set_vecs(0, 1, 2, 3, 4, 5, 6, 7);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || result !== '0 || overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL midflight_async got v=%b r=%0d o=%b want 0/0/0", out_valid, result, overflow);
      end
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_cmp++;
         if (out_valid !== 1'b0 || result !== '0) begin
            n_bad++;
            $display("FAIL midflight_drop cyc%0d got v=%b r=%0d want 0/0", c, out_valid, result);
         end
      end
      // Pipeline must still work after the interrupted transaction.
      set_vecs(2, 0, 0, 0, 5, 0, 0, 0);
      run_single("after_reset", DW'(10), 1'b0);
   endtask

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      set_vecs(0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_basic();
      test_zero();
      test_back_to_back();
      test_overflow();
      test_boundary();
      test_basic();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
